// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - time-of-day counter, button set logic and display scan phase (optional debouncer: TIME_KEEPER_DEBOUNCE_EN)
module time_keeper #(
  parameter int TICKS_PER_SEC   = 10000000,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        show_hours,
  input  logic        btn_inc_min,
  input  logic        btn_inc_hour,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic        tick_1hz
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [4:0]    r_hour;
  logic          r_tick;
  logic [11:0]   r_data;
  logic [SW-1:0] r_scan_presc;
  logic [2:0]    r_byte;

  logic          r_min_s1;
  logic          r_min_s2;
  logic          r_hour_s1;
  logic          r_hour_s2;
  logic          r_min_lvl_d;
  logic          r_hour_lvl_d;

  logic          w_tick;
  logic          w_min_lvl;
  logic          w_hour_lvl;
  logic          w_min_press;
  logic          w_hour_press;
  logic          w_sec_carry;
  logic          w_min_carry;
  logic [5:0]    w_sec_nxt;
  logic [5:0]    w_min_nxt;
  logic [4:0]    w_hour_nxt;
  logic [6:0]    w_min_sum;
  logic [5:0]    w_hour_sum;

  // Two-flop synchronizers bring the asynchronous buttons into the clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      r_min_s1  <= 1'b0;
      r_min_s2  <= 1'b0;
      r_hour_s1 <= 1'b0;
      r_hour_s2 <= 1'b0;
    end else begin
      r_min_s1  <= btn_inc_min;
      r_min_s2  <= r_min_s1;
      r_hour_s1 <= btn_inc_hour;
      r_hour_s2 <= r_hour_s1;
    end
  end

`ifdef TIME_KEEPER_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] r_min_db_cnt;
  logic [DW-1:0] r_hour_db_cnt;
  logic          r_min_db;
  logic          r_hour_db;

  // Debounced level follows sync2 only after it has disagreed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clock) begin
    if (reset) begin
      r_min_db_cnt  <= '0;
      r_hour_db_cnt <= '0;
      r_min_db      <= 1'b0;
      r_hour_db     <= 1'b0;
    end else begin
      if (r_min_s2 == r_min_db) begin
        r_min_db_cnt <= '0;
      end else if (r_min_db_cnt == DB_LAST) begin
        r_min_db     <= r_min_s2;
        r_min_db_cnt <= '0;
      end else begin
        r_min_db_cnt <= r_min_db_cnt + DW'(1);
      end
      if (r_hour_s2 == r_hour_db) begin
        r_hour_db_cnt <= '0;
      end else if (r_hour_db_cnt == DB_LAST) begin
        r_hour_db     <= r_hour_s2;
        r_hour_db_cnt <= '0;
      end else begin
        r_hour_db_cnt <= r_hour_db_cnt + DW'(1);
      end
    end
  end

  assign w_min_lvl  = r_min_db;
  assign w_hour_lvl = r_hour_db;
`else
  assign w_min_lvl  = r_min_s2;
  assign w_hour_lvl = r_hour_s2;
`endif

  // Edge registers turn each button level into a single-cycle press pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_min_lvl_d  <= 1'b0;
      r_hour_lvl_d <= 1'b0;
    end else begin
      r_min_lvl_d  <= w_min_lvl;
      r_hour_lvl_d <= w_hour_lvl;
    end
  end

  assign w_min_press  = w_min_lvl & ~r_min_lvl_d;
  assign w_hour_press = w_hour_lvl & ~r_hour_lvl_d;

  // The tick fires on the last prescaler count, but only while time is running
  assign w_tick = run && (r_presc == PRESC_LAST);

  // Second prescaler: counts while running, holds its value while frozen
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else if (run) begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Next-state of the time chain; tick carry and button press are summed, only the tick carries into hours
  always_comb begin
    w_sec_carry = w_tick && (r_sec == 6'd59);
    w_min_carry = w_sec_carry && (r_min == 6'd59);
    w_sec_nxt   = r_sec;
    if (w_tick) begin
      w_sec_nxt = w_sec_carry ? 6'd0 : r_sec + 6'd1;
    end
    w_min_sum  = {1'b0, r_min} + {6'd0, w_sec_carry} + {6'd0, w_min_press};
    w_min_nxt  = (w_min_sum >= 7'd60) ? 6'(w_min_sum - 7'd60) : w_min_sum[5:0];
    w_hour_sum = {1'b0, r_hour} + {5'd0, w_min_carry} + {5'd0, w_hour_press};
    w_hour_nxt = (w_hour_sum >= 6'd24) ? 5'(w_hour_sum - 6'd24) : w_hour_sum[4:0];
  end

  // Time registers and the registered tick pulse, which lines up with the new counter values
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
      r_tick <= 1'b0;
    end else begin
      r_sec  <= w_sec_nxt;
      r_min  <= w_min_nxt;
      r_hour <= w_hour_nxt;
      r_tick <= w_tick;
    end
  end

  // Registered display field pair: hours:minutes or minutes:seconds
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data <= '0;
    end else if (show_hours) begin
      r_data <= {1'b0, r_hour, r_min};
    end else begin
      r_data <= {r_min, r_sec};
    end
  end

  // Free-running scan phase: advances once per SCAN_DIV cycles regardless of run
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan_presc <= '0;
      r_byte       <= '0;
    end else if (r_scan_presc == SCAN_LAST) begin
      r_scan_presc <= '0;
      r_byte       <= r_byte + 3'd1;
    end else begin
      r_scan_presc <= r_scan_presc + SW'(1);
    end
  end

  assign data_show   = r_data;
  assign byte_status = r_byte;
  assign tick_1hz    = r_tick;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed, table-driven bench for time_keeper (TICKS_PER_SEC=4, SCAN_DIV=3, DEBOUNCE_CYCLES=8)
module tb_time_keeper;

  localparam int TPS = 4;
`ifdef TIME_KEEPER_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  localparam int PRESS_HOLD = (DB == 0) ? 3 : 12;

  logic        clock;
  logic        reset;
  logic        run;
  logic        show_hours;
  logic        btn_inc_min;
  logic        btn_inc_hour;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic        tick_1hz;

  int total = 0;
  int bad   = 0;

  time_keeper #(
    .TICKS_PER_SEC  (TPS),
    .SCAN_DIV       (3),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .show_hours  (show_hours),
    .btn_inc_min (btn_inc_min),
    .btn_inc_hour(btn_inc_hour),
    .data_show   (data_show),
    .byte_status (byte_status),
    .tick_1hz    (tick_1hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic sh;
    int   nmin;
    int   nhour;
    int   hi;
    int   lo;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [11:0] f(input int hi, input int lo);
    return {6'(hi), 6'(lo)};
  endfunction

  task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d:%0d want %0d:%0d", name, act[11:6], act[5:0], exp[11:6], exp[5:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc_min = 1'b1;
      repeat (PRESS_HOLD) @(negedge clock);
      btn_inc_min = 1'b0;
      repeat (PRESS_HOLD) @(negedge clock);
    end
  endtask

  task automatic press_hour(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc_hour = 1'b1;
      repeat (PRESS_HOLD) @(negedge clock);
      btn_inc_hour = 1'b0;
      repeat (PRESS_HOLD) @(negedge clock);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int first;
    int ticks;
    int stable;
    int n;
    int base;

    vecs[0] = '{1'b0, 0,  0,  0,  0};
    vecs[1] = '{1'b0, 3,  0,  3,  0};
    vecs[2] = '{1'b1, 0,  2,  2,  3};
    vecs[3] = '{1'b1, 0,  22, 0,  3};
    vecs[4] = '{1'b0, 56, 0,  59, 0};
    vecs[5] = '{1'b1, 1,  0,  0,  0};
    vecs[6] = '{1'b1, 0,  23, 23, 0};

    reset = 1'b1; run = 1'b0; show_hours = 1'b0;
    btn_inc_min = 1'b0; btn_inc_hour = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // arbitrary state, then a single-cycle reset
    run = 1'b1;
    press_min(1);
    press_hour(1);
    repeat (7) @(negedge clock);
    do_reset();
    check12("reset_data", data_show, f(0, 0));
    check_int("reset_byte", int'(byte_status), 0);
    check_int("reset_tick", int'(tick_1hz), 0);

    // first tick exactly TPS cycles after reset release
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      @(negedge clock);
      if (tick_1hz) first = i;
    end
    check_int("first_tick", first, TPS);
    run = 1'b0;
    @(negedge clock);
    check_int("tick_width", int'(tick_1hz), 0);
    check12("after_first_tick", data_show, f(0, 1));

    // set mode vectors with time frozen
    do_reset();
    for (int v = 0; v < 7; v++) begin
      press_min(vecs[v].nmin);
      press_hour(vecs[v].nhour);
      show_hours = vecs[v].sh;
      repeat (2) @(negedge clock);
      check12($sformatf("vec%0d", v), data_show, f(vecs[v].hi, vecs[v].lo));
    end

    // rollover from 23:59:59
    show_hours = 1'b0;
    press_min(59);
    run = 1'b1;
    repeat (59 * TPS) @(negedge clock);
    run = 1'b0;
    repeat (2) @(negedge clock);
    check12("roll_pre_ms", data_show, f(59, 59));
    show_hours = 1'b1;
    repeat (2) @(negedge clock);
    check12("roll_pre_hm", data_show, f(23, 59));
    ticks = 0;
    run = 1'b1;
    for (int i = 0; i < TPS; i++) begin
      @(negedge clock);
      if (tick_1hz) ticks++;
    end
    run = 1'b0;
    repeat (2) @(negedge clock);
    check_int("roll_ticks", ticks, 1);
    check12("roll_hm", data_show, f(0, 0));
    show_hours = 1'b0;
    repeat (2) @(negedge clock);
    check12("roll_ms", data_show, f(0, 0));

    // collision of minute press with a carrying tick at 05:59:59
    press_hour(5);
    press_min(59);
    run = 1'b1;
    repeat (59 * TPS) @(negedge clock);
    run = 1'b0;
    repeat (2) @(negedge clock);
    check12("coll_pre", data_show, f(59, 59));
    if (DB == 0) begin
      run = 1'b1;
      @(negedge clock);
      btn_inc_min = 1'b1;
      repeat (3) @(negedge clock);
    end else begin
      btn_inc_min = 1'b1;
      repeat (DB - 1) @(negedge clock);
      run = 1'b1;
      repeat (4) @(negedge clock);
    end
    run = 1'b0;
    btn_inc_min = 1'b0;
    repeat (PRESS_HOLD) @(negedge clock);
    show_hours = 1'b1;
    repeat (2) @(negedge clock);
    check12("coll_hm", data_show, f(6, 1));
    show_hours = 1'b0;
    repeat (2) @(negedge clock);
    check12("coll_ms", data_show, f(1, 0));

    // run hold: frozen time, buttons still effective
    ticks = 0;
    stable = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tick_1hz) ticks++;
      if (data_show !== f(1, 0)) stable = 0;
    end
    check_int("hold_ticks", ticks, 0);
    check_int("hold_stable", stable, 1);
    show_hours = 1'b1;
    press_hour(17);
    check12("hold_h23", data_show, f(23, 1));
    press_hour(1);
    check12("hold_h0", data_show, f(0, 1));

    // scan phase sequence with run low
    show_hours = 1'b0;
    do_reset();
    for (int i = 0; i < 27; i++) begin
      check_int($sformatf("scan%0d", i), int'(byte_status), (i / 3) % 8);
      @(negedge clock);
    end

    // glitch rejection and press latency
    do_reset();
    btn_inc_min = 1'b1;
    repeat (5) @(negedge clock);
    btn_inc_min = 1'b0;
    repeat (20) @(negedge clock);
    base = (DB == 0) ? 1 : 0;
    check12("glitch", data_show, f(base, 0));
    btn_inc_min = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clock);
      if (data_show !== f(base, 0)) n = i;
    end
    check_int("press_latency", n, 4 + DB);
    repeat (20) @(negedge clock);
    btn_inc_min = 1'b0;
    repeat (20) @(negedge clock);
    check12("press_once", data_show, f(base + 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
